clip_record_play_controller: RTL and testbench
==============================================

// Module: clip_record_play_controller
// PURPOSE
//  Consumer of the synchronized button outputs. Receives one-clock-domain ActionSync,
//  ClipNumSync, PlayOrRecordSync and resetButtonSync and runs the clip record/playback FSM.
//  Records mic samples into the clip memory and plays them back to the speaker path.
//  Holds a length register per clip. Sits between the synchronizer and the clip RAM/audio I/O.
// PARAMETERS
//  SAMPLE_W   8    width of mic/speaker samples and memory data
//  ADDR_W     12   per-clip address width; clip capacity = 2**ADDR_W samples
//                  NUM_CLIPS is fixed at 2, indexed by a 1-bit ClipNumSync.
// PORTS
//  clock             in   1            system clock, all logic on posedge
//  reset             in   1            synchronous, active-high; full reset
//  ActionSync        in   1            synchronized action button (level)
//  ClipNumSync       in   1            clip select (0/1)
//  PlayOrRecordSync  in   1            1=record, 0=play
//  resetButtonSync   in   1            user erase: clears clip lengths, aborts op
//  sample_tick       in   1            1-cycle sample-rate strobe
//  mic_sample        in   SAMPLE_W     audio input sample
//  mem_addr          out  ADDR_W+1     {clip, index} to clip RAM
//  mem_we            out  1            write strobe (1 cycle)
//  mem_re            out  1            read strobe (1 cycle); mem_rdata valid next cycle
//  mem_wdata         out  SAMPLE_W     write data
//  mem_rdata         in   SAMPLE_W     read data, 1-cycle latency after mem_re
//  speaker_sample    out  SAMPLE_W     playback sample, held between ticks
//  recording         out  1            high in RECORD
//  playing           out  1            high in PLAY
//  done              out  1            1-cycle pulse when an operation ends
// BEHAVIOUR
//  Reset (reset=1 at posedge): state=IDLE; all outputs 0; len[0]=len[1]=0; idx=0;
//    act_prev=1, so a button held through reset does not trigger.
//  act_edge = ActionSync & ~act_prev; act_prev <= ActionSync every cycle.
//  States: IDLE, RECORD, PLAY, FINISH. len[c] and idx are ADDR_W+1 bits (0..2**ADDR_W).
//  IDLE: on act_edge, latch clip<=ClipNumSync and mode<=PlayOrRecordSync; idx<=0.
//    mode=1 -> RECORD.
//    mode=0 and len[clip]!=0 -> PLAY.
//    mode=0 and len[clip]==0 -> FINISH.
//    sample_tick is ignored in IDLE.
//  RECORD: on sample_tick, in the same cycle: mem_we=1, mem_addr={clip,idx[ADDR_W-1:0]},
//    mem_wdata=mic_sample; idx<=idx+1.
//    Exit to FINISH on act_edge, or when the write at idx=2**ADDR_W-1 completes (clip full).
//    On exit, len[clip]<=samples written. A tick and act_edge in the same cycle: sample is
//    written and counted, then exit. No wrap-around; writes never cross into the other clip.
//  PLAY: on sample_tick with idx<len[clip]: mem_re=1, mem_addr={clip,idx}; idx<=idx+1.
//    The cycle after mem_re: speaker_sample<=mem_rdata.
//    After the final read's data lands -> FINISH.
//    act_edge aborts -> FINISH immediately; any pending read data is discarded.
//  FINISH: done=1 for exactly one cycle; speaker_sample<=0; -> IDLE. act_edge ignored here.
//  Latched clip/mode are stable for the whole op; input changes mid-op are ignored.
//  resetButtonSync=1 (sync, any state): len[0]=len[1]=0, state->IDLE, mem_we/mem_re=0,
//    speaker_sample=0, done=0. act_prev still tracks. Overrides act_edge in the same cycle.
//  reset has priority over resetButtonSync.
//  mem_we and mem_re are never high together. Outputs are registered except mem_* strobes,
//    which are decoded from the registered state together with sample_tick.
// TESTING
//  1) reset; rec clip0 (PRS=1,CN=0, press); 5 ticks; press -> 5 writes addr 0x000..0x004;
//     len0=5; done pulse.
//  2) play clip0 -> 5 mem_re, addr 0x000..0x004; speaker_sample = the 5 recorded values,
//     1 cycle after each re; then done, speaker=0.
//  3) ADDR_W=3: rec clip1 with 10 ticks -> exactly 8 writes addr 0x8..0xF; auto-FINISH; len1=8.
//  4) play empty clip1 after resetButtonSync -> no mem_re; done 1 cycle after press.
//  5) press mid-play at idx=2 -> immediate FINISH, no further re; tick+press same cycle in
//     RECORD -> sample counted.
//  6) ActionSync held high across reset release -> no op starts; resetButtonSync mid-RECORD
//     -> IDLE, len=0, no done.

Source files
------------

// File: rtl/clip_record_play_controller.sv
// Two-clip record/playback FSM between the button synchronizer and the clip RAM; strobes are combinational from state+tick,
// speaker data lands one cycle after the read strobe; no backpressure, the sample_tick strobe paces all memory traffic.
module clip_record_play_controller #(
    parameter int SAMPLE_W = 8,
    parameter int ADDR_W   = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ActionSync,
    input  logic                ClipNumSync,
    input  logic                PlayOrRecordSync,
    input  logic                resetButtonSync,
    input  logic                sample_tick,
    input  logic [SAMPLE_W-1:0] mic_sample,
    output logic [ADDR_W:0]     mem_addr,
    output logic                mem_we,
    output logic                mem_re,
    output logic [SAMPLE_W-1:0] mem_wdata,
    input  logic [SAMPLE_W-1:0] mem_rdata,
    output logic [SAMPLE_W-1:0] speaker_sample,
    output logic                recording,
    output logic                playing,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, RECORD, PLAY, FINISH} state_t;

    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

    state_t          state, state_nxt;
    logic            act_prev;
    logic            act_edge;
    logic            clip;
    logic [ADDR_W:0] len0, len1;
    logic [ADDR_W:0] cur_len;
    logic [ADDR_W:0] idx;
    logic            rd_pending;
    logic            wr_fire;
    logic            rd_fire;

    assign act_edge = ActionSync & ~act_prev;
    assign cur_len  = clip ? len1 : len0;

    // An abort press or an erase in the same cycle suppresses the strobe that tick would have fired.
    assign wr_fire = (state == RECORD) && sample_tick && !resetButtonSync;
    assign rd_fire = (state == PLAY) && sample_tick && (idx < cur_len) && !act_edge && !resetButtonSync;

    assign mem_we    = wr_fire;
    assign mem_re    = rd_fire;
    assign mem_addr  = {clip, idx[ADDR_W-1:0]};
    assign mem_wdata = mic_sample;

    assign recording = (state == RECORD);
    assign playing   = (state == PLAY);
    assign done      = (state == FINISH);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (act_edge) begin
                    if (PlayOrRecordSync)
                        state_nxt = RECORD;
                    else if ((ClipNumSync ? len1 : len0) != '0)
                        state_nxt = PLAY;
                    else
                        state_nxt = FINISH;
                end
            end
            RECORD: begin
                if (act_edge || (sample_tick && idx == LAST_IDX))
                    state_nxt = FINISH;
            end
            PLAY: begin
                if (act_edge || (rd_pending && idx == cur_len))
                    state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (resetButtonSync)
            state_nxt = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            act_prev       <= 1'b1;
            clip           <= 1'b0;
            len0           <= '0;
            len1           <= '0;
            idx            <= '0;
            rd_pending     <= 1'b0;
            speaker_sample <= '0;
        end else begin
            act_prev   <= ActionSync;
            state      <= state_nxt;
            rd_pending <= rd_fire;
            if (resetButtonSync) begin
                len0           <= '0;
                len1           <= '0;
                idx            <= '0;
                speaker_sample <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (act_edge) begin
                            clip <= ClipNumSync;
                            idx  <= '0;
                        end
                    end
                    RECORD: begin
                        if (wr_fire)
                            idx <= idx + 1'b1;
                        // Length counts the sample written in the exit cycle, if any.
                        if (state_nxt == FINISH) begin
                            if (clip)
                                len1 <= idx + {{ADDR_W{1'b0}}, wr_fire};
                            else
                                len0 <= idx + {{ADDR_W{1'b0}}, wr_fire};
                        end
                    end
                    PLAY: begin
                        if (rd_pending && !act_edge)
                            speaker_sample <= mem_rdata;
                        if (rd_fire)
                            idx <= idx + 1'b1;
                    end
                    FINISH:  speaker_sample <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clip_record_play_controller.sv
// Directed bench for clip_record_play_controller with a 3-bit per-clip address and a 1-cycle RAM model.
module tb_clip_record_play_controller;

    localparam int SW = 8;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          ActionSync;
    logic          ClipNumSync;
    logic          PlayOrRecordSync;
    logic          resetButtonSync;
    logic          sample_tick;
    logic [SW-1:0] mic_sample;
    logic [AW:0]   mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [SW-1:0] mem_wdata;
    logic [SW-1:0] mem_rdata;
    logic [SW-1:0] speaker_sample;
    logic          recording;
    logic          playing;
    logic          done;

    always #5 clock = ~clock;

    clip_record_play_controller #(.SAMPLE_W(SW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .ActionSync(ActionSync), .ClipNumSync(ClipNumSync),
        .PlayOrRecordSync(PlayOrRecordSync), .resetButtonSync(resetButtonSync),
        .sample_tick(sample_tick), .mic_sample(mic_sample), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .speaker_sample(speaker_sample), .recording(recording), .playing(playing), .done(done)
    );

    logic [SW-1:0] mem [16];
    int n_we = 0, n_re = 0, n_both = 0;

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) n_we <= n_we + 1;
        if (mem_re) n_re <= n_re + 1;
        if (mem_we && mem_re) n_both <= n_both + 1;
    end

    int n_cmp = 0;
    int n_err = 0;
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic press();
        ActionSync = 1'b1;
        cyc();
        ActionSync = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ActionSync = 1'b0; ClipNumSync = 1'b0; PlayOrRecordSync = 1'b0;
        resetButtonSync = 1'b0; sample_tick = 1'b0; mic_sample = '0;
        cyc(); cyc();
        chk("rst_recording", recording, 0);
        chk("rst_playing", playing, 0);
        chk("rst_done", done, 0);
        chk("rst_speaker", speaker_sample, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_re", mem_re, 0);
        reset = 1'b0;
        cyc();

        // Record five samples into clip 0.
        PlayOrRecordSync = 1'b1; ClipNumSync = 1'b0;
        base = n_we;
        press();
        chk("t1_recording", recording, 1);
        for (int i = 0; i < 5; i++) begin
            sample_tick = 1'b1; mic_sample = 8'(8'hA0 + i);
            #1;
            chk("t1_we", mem_we, 1);
            chk("t1_addr", mem_addr, i);
            chk("t1_wdata", mem_wdata, 8'hA0 + i);
            cyc();
            sample_tick = 1'b0;
        end
        press();
        chk("t1_done", done, 1);
        chk("t1_rec_off", recording, 0);
        chk("t1_nwe", n_we - base, 5);
        cyc();
        chk("t1_done_pulse", done, 0);

        // Play clip 0 back, one tick every other cycle.
        PlayOrRecordSync = 1'b0;
        base = n_re;
        press();
        chk("t2_playing", playing, 1);
        for (int i = 0; i < 5; i++) begin
            sample_tick = 1'b1;
            #1;
            chk("t2_re", mem_re, 1);
            chk("t2_addr", mem_addr, i);
            cyc();
            sample_tick = 1'b0;
            cyc();
            chk("t2_speaker", speaker_sample, 8'hA0 + i);
            chk("t2_done", done, (i == 4) ? 1 : 0);
        end
        chk("t2_nre", n_re - base, 5);
        cyc();
        chk("t2_spk_clear", speaker_sample, 0);
        chk("t2_done_pulse", done, 0);

        // Record clip 1 with ten ticks; only eight fit.
        PlayOrRecordSync = 1'b1; ClipNumSync = 1'b1;
        base = n_we;
        press();
        for (int i = 0; i < 10; i++) begin
            sample_tick = 1'b1; mic_sample = 8'(8'h10 + i);
            #1;
            chk("t3_we", mem_we, (i < 8) ? 1 : 0);
            if (i < 8) chk("t3_addr", mem_addr, 8 + i);
            if (i == 8) chk("t3_done", done, 1);
            cyc();
        end
        sample_tick = 1'b0;
        chk("t3_nwe", n_we - base, 8);

        // Play clip 1 with continuous ticks; length must be 8.
        PlayOrRecordSync = 1'b0;
        base = n_re;
        press();
        for (int i = 0; i < 10; i++) begin
            sample_tick = 1'b1;
            #1;
            if (i == 9) begin
                chk("t3p_done", done, 1);
                chk("t3p_last", speaker_sample, 8'h17);
            end
            cyc();
        end
        sample_tick = 1'b0;
        chk("t3p_nre", n_re - base, 8);
        chk("t3p_spk_clear", speaker_sample, 0);

        // Erase, then play the now-empty clips.
        resetButtonSync = 1'b1;
        cyc();
        resetButtonSync = 1'b0;
        base = n_re;
        ClipNumSync = 1'b1;
        press();
        chk("t4_done1", done, 1);
        chk("t4_playing1", playing, 0);
        cyc();
        ClipNumSync = 1'b0;
        press();
        chk("t4_done0", done, 1);
        chk("t4_nre", n_re - base, 0);
        cyc();

        // Record clip 0: three ticks, then tick and press together.
        PlayOrRecordSync = 1'b1;
        press();
        for (int i = 0; i < 3; i++) begin
            sample_tick = 1'b1; mic_sample = 8'(8'h50 + i);
            cyc();
            sample_tick = 1'b0;
        end
        sample_tick = 1'b1; mic_sample = 8'h53; ActionSync = 1'b1;
        #1;
        chk("t5_we_last", mem_we, 1);
        chk("t5_addr_last", mem_addr, 3);
        cyc();
        ActionSync = 1'b0; sample_tick = 1'b0;
        chk("t5_rec_done", done, 1);
        cyc();

        // Abort playback at idx=2.
        PlayOrRecordSync = 1'b0;
        base = n_re;
        press();
        for (int i = 0; i < 2; i++) begin
            sample_tick = 1'b1;
            cyc();
            sample_tick = 1'b0;
            cyc();
        end
        chk("t5_spk_mid", speaker_sample, 8'h51);
        sample_tick = 1'b1; ActionSync = 1'b1;
        #1;
        chk("t5_abort_re", mem_re, 0);
        cyc();
        ActionSync = 1'b0; sample_tick = 1'b0;
        chk("t5_abort_done", done, 1);
        chk("t5_abort_playing", playing, 0);
        chk("t5_abort_nre", n_re - base, 2);
        cyc();

        // Clip 0 length must be 4, including the tick taken with the press.
        base = n_re;
        press();
        sample_tick = 1'b1;
        repeat (6) cyc();
        sample_tick = 1'b0;
        chk("t5_len0", n_re - base, 4);
        cyc();

        // Erase in the middle of a recording.
        PlayOrRecordSync = 1'b1; ClipNumSync = 1'b1;
        press();
        sample_tick = 1'b1; mic_sample = 8'h60;
        cyc(); cyc();
        resetButtonSync = 1'b1;
        #1;
        chk("t6_erase_we", mem_we, 0);
        cyc();
        resetButtonSync = 1'b0; sample_tick = 1'b0;
        chk("t6_erase_rec", recording, 0);
        chk("t6_erase_done", done, 0);
        cyc();
        chk("t6_erase_done2", done, 0);
        PlayOrRecordSync = 1'b0; ClipNumSync = 1'b0;
        base = n_re;
        press();
        chk("t6_len0_erased", done, 1);
        chk("t6_nre", n_re - base, 0);
        cyc();

        // Button held high through reset release must not start an operation.
        PlayOrRecordSync = 1'b1;
        ActionSync = 1'b1; reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_held_rec", recording, 0);
            chk("t6_held_done", done, 0);
        end
        ActionSync = 1'b0;
        cyc();

        chk("never_we_re", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
